// File: rtl/uart_div_display_pkg.sv
// Shared types and constants for the UART divide/display block.
`timescale 1ns/1ps
package uart_div_display_pkg;

  localparam logic [7:0] CMD_BYTE_DEFAULT = 8'h73;  // 's'

  // Clocks per UART bit period.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_CMD1,
    WAIT_A,
    WAIT_CMD2,
    WAIT_B,
    DIVIDE,
    SEND
  } ctl_state_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F (lowercase b, d).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/uart_div_display_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, centre sampling, one-cycle byte strobe.
`timescale 1ns/1ps
module uart_div_rx
  import uart_div_display_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state, w_next;
  logic          r_sync1, r_sync2, r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          w_fall, w_half, w_full;

  assign w_fall  = r_rx_d & ~r_sync2;
  assign w_half  = (r_cnt == HALF_M1);
  assign w_full  = (r_cnt == FULL_M1);
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Synchronize rx and keep one delayed copy for falling-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  // Next state: a start bit that is no longer low at half-bit is a glitch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Bit timing, LSB-first shift and stop-bit qualified strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        RX_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_div_display.sv
// Two-operand UART divide command: receive, divide, show on 7-seg, hand bytes to TX.
`timescale 1ns/1ps
module uart_div_display
  import uart_div_display_pkg::*;
#(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 9600,
  parameter int         SCAN_CLKS = 50_000,
  parameter int         TX_GAP    = 12 * calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter logic [7:0] CMD_BYTE  = CMD_BYTE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_ready,
  output logic [23:0] o_y_to_led,
  output logic [6:0]  o_led_out,
  output logic [5:0]  o_dig
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int GW = $clog2(TX_GAP + 1);
  localparam int SW = $clog2(SCAN_CLKS);
  localparam logic [GW-1:0] GAP_M1  = GW'(TX_GAP - 1);
  localparam logic [SW-1:0] SCAN_M1 = SW'(SCAN_CLKS - 1);

  logic [7:0]  w_rx_data;
  logic        w_rx_vld;

  ctl_state_t  r_state, w_next;
  logic [7:0]  r_a, r_div, r_rem;
  logic [23:0] r_quo, r_y;
  logic [4:0]  r_step;
  logic [GW-1:0] r_gap;
  logic [1:0]  r_tx_idx;
  logic [7:0]  r_tx_data, w_tx_byte;
  logic        r_tx_ready;

  logic [8:0]  w_shift;
  logic [9:0]  w_diff;
  logic        w_ge;
  logic [7:0]  w_rem_nxt;
  logic [23:0] w_quo_nxt;

  logic [SW-1:0] r_scan;
  logic [2:0]  r_digit;
  logic [5:0]  r_dig;
  logic [6:0]  r_led;
  logic [3:0]  w_nib;

  uart_div_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rx    (i_rx),
    .o_data  (w_rx_data),
    .o_valid (w_rx_vld)
  );

  // Restoring divide step: the remainder never exceeds the 8-bit divisor.
  assign w_shift   = {r_rem, r_quo[23]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge      = ~w_diff[9];
  assign w_rem_nxt = w_ge ? w_diff[7:0] : w_shift[7:0];
  assign w_quo_nxt = {r_quo[22:0], w_ge};

  // Controller state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= WAIT_CMD1;
    else       r_state <= w_next;
  end

  // Command protocol; a zero divisor bypasses the divider.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_CMD1: if (w_rx_vld && w_rx_data == CMD_BYTE) w_next = WAIT_A;
      WAIT_A:    if (w_rx_vld) w_next = WAIT_CMD2;
      WAIT_CMD2: if (w_rx_vld) w_next = (w_rx_data == CMD_BYTE) ? WAIT_B : WAIT_CMD1;
      WAIT_B:    if (w_rx_vld) w_next = (w_rx_data == 8'h00) ? SEND : DIVIDE;
      DIVIDE:    if (r_step == 5'd23) w_next = SEND;
      SEND:      if (r_gap == '0 && r_tx_idx == 2'd2) w_next = WAIT_CMD1;
      default:   w_next = WAIT_CMD1;
    endcase
  end

  // Result byte for the current transmit slot, MSB first.
  always_comb begin
    w_tx_byte = r_y[7:0];
    case (r_tx_idx)
      2'd0:    w_tx_byte = r_y[23:16];
      2'd1:    w_tx_byte = r_y[15:8];
      default: ;
    endcase
  end

  // Operand capture, divider iteration, result latch and TX pacing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a        <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_y        <= '0;
      r_step     <= '0;
      r_gap      <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      if (r_state != SEND) begin
        r_gap    <= '0;
        r_tx_idx <= '0;
      end
      case (r_state)
        WAIT_A: if (w_rx_vld) r_a <= w_rx_data;
        WAIT_B: begin
          if (w_rx_vld) begin
            r_quo  <= {16'h0000, r_a};
            r_div  <= w_rx_data;
            r_rem  <= '0;
            r_step <= '0;
            if (w_rx_data == 8'h00) r_y <= 24'hFFFFFF;
          end
        end
        DIVIDE: begin
          r_rem  <= w_rem_nxt;
          r_quo  <= w_quo_nxt;
          r_step <= r_step + 1'b1;
          if (r_step == 5'd23) r_y <= w_quo_nxt;
        end
        SEND: begin
          if (r_gap == '0) begin
            r_tx_ready <= 1'b1;
            r_tx_data  <= w_tx_byte;
            r_gap      <= GAP_M1;
            if (r_tx_idx != 2'd2) r_tx_idx <= r_tx_idx + 1'b1;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_nib = r_y[{r_digit, 2'b00} +: 4];

  // Digit scanner: registered select and glyph switch together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan  <= '0;
      r_digit <= '0;
      r_dig   <= 6'h3F;
      r_led   <= 7'h7F;
    end else begin
      r_dig <= ~(6'b000001 << r_digit);
      r_led <= SEG_TABLE[w_nib];
      if (r_scan == SCAN_M1) begin
        r_scan  <= '0;
        r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_ready = r_tx_ready;
  assign o_y_to_led = r_y;
  assign o_led_out  = r_led;
  assign o_dig      = r_dig;

endmodule

// File: tb/tb_uart_div_display.sv
// Directed bench for uart_div_display with a fast baud rate and short scan period.
`timescale 1ns/1ps
module tb_uart_div_display;

  localparam int CPB    = 16;
  localparam int SCAN   = 40;
  localparam int GAP    = 12 * CPB;
  localparam int BIT_NS = CPB * 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [23:0] y;
  logic [6:0]  led;
  logic [5:0]  dig;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] txq[$];
  int         txt[$];

  uart_div_display #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .SCAN_CLKS(SCAN), .TX_GAP(GAP), .CMD_BYTE(8'h73)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_tx_data(tx_data), .o_tx_ready(tx_ready), .o_y_to_led(y),
    .o_led_out(led), .o_dig(dig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_ready) begin
      txq.push_back(tx_data);
      txt.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0; #BIT_NS;
    for (int i = 0; i < 8; i++) begin rx = b[i]; #BIT_NS; end
    rx = stop; #BIT_NS;
    rx = 1'b1; #(BIT_NS * 2);
  endtask

  task automatic send4(input logic [7:0] a, b, c, d);
    send_byte(a); send_byte(b); send_byte(c); send_byte(d);
  endtask

  task automatic wait_y(input logic [23:0] exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (y === exp) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 3 * GAP + 200; i++) begin
      @(negedge clk);
      if (txq.size() >= n) break;
    end
  endtask

  task automatic wait_dig(input logic [5:0] d);
    for (int i = 0; i < 7 * SCAN; i++) begin
      @(negedge clk);
      if (dig === d) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #20;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
    checks++; if (y !== 24'h0) begin errors++; $display("FAIL rst_y: got %h want 000000", y); end
    checks++; if (led !== 7'h7F) begin errors++; $display("FAIL rst_led: got %h want 7f", led); end
    checks++; if (dig !== 6'h3F) begin errors++; $display("FAIL rst_dig: got %b want 111111", dig); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (dig !== 6'h3E) begin errors++; $display("FAIL scan_first: got %b want 111110", dig); end
    checks++; if (led !== 7'h40) begin errors++; $display("FAIL scan_glyph0: got %h want 40", led); end
    repeat (SCAN - 1) @(posedge clk); #1;
    checks++; if (dig !== 6'h3E) begin errors++; $display("FAIL scan_hold: got %b want 111110", dig); end
    @(posedge clk); #1;
    checks++; if (dig !== 6'h3D) begin errors++; $display("FAIL scan_d1: got %b want 111101", dig); end
    repeat (4 * SCAN) @(posedge clk); #1;
    checks++; if (dig !== 6'h1F) begin errors++; $display("FAIL scan_d5: got %b want 011111", dig); end
    repeat (SCAN) @(posedge clk); #1;
    checks++; if (dig !== 6'h3E) begin errors++; $display("FAIL scan_wrap: got %b want 111110", dig); end
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL rst_no_tx: got %0d pulses want 0", txq.size()); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h03};
    txq.delete(); txt.delete();
    send4(8'h73, 8'h03, 8'h73, 8'h01);
    wait_y(24'h000003, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_y: got %h want 000003", y); end
    wait_tx(3);
    checks++; if (txq.size() != 3) begin errors++; $display("FAIL basic_tx_count: got %0d want 3", txq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL basic_tx_byte%0d: got %h want %h", i, txq[i], exp[i]); end
      end
      checks++; if (txt[1] - txt[0] != GAP || txt[2] - txt[1] != GAP)
        begin errors++; $display("FAIL basic_tx_gap: got %0d,%0d want %0d", txt[1] - txt[0], txt[2] - txt[1], GAP); end
    end
    repeat (5) @(negedge clk);
    checks++; if (tx_data !== 8'h03) begin errors++; $display("FAIL basic_tx_hold: got %h want 03", tx_data); end
    wait_dig(6'h3E);
    checks++; if (led !== 7'h30) begin errors++; $display("FAIL basic_glyph_d0: got %h want 30", led); end
    wait_dig(6'h3D);
    checks++; if (led !== 7'h40) begin errors++; $display("FAIL basic_glyph_d1: got %h want 40", led); end
  endtask

  task automatic test_nonexact();
    bit ok;
    logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h0F};
    txq.delete(); txt.delete();
    send4(8'h73, 8'hFF, 8'h73, 8'h10);
    wait_y(24'h00000F, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nonexact_y: got %h want 00000f", y); end
    wait_tx(3);
    checks++; if (txq.size() != 3) begin errors++; $display("FAIL nonexact_tx_count: got %0d want 3", txq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL nonexact_tx_byte%0d: got %h want %h", i, txq[i], exp[i]); end
    end
    wait_dig(6'h3E);
    checks++; if (led !== 7'h0E) begin errors++; $display("FAIL nonexact_glyph_d0: got %h want 0e", led); end
  endtask

  task automatic test_div_zero();
    bit ok;
    txq.delete(); txt.delete();
    send4(8'h73, 8'h05, 8'h73, 8'h00);
    wait_y(24'hFFFFFF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL divzero_y: got %h want ffffff", y); end
    wait_tx(3);
    checks++; if (txq.size() != 3) begin errors++; $display("FAIL divzero_tx_count: got %0d want 3", txq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (txq[i] !== 8'hFF) begin errors++; $display("FAIL divzero_tx_byte%0d: got %h want ff", i, txq[i]); end
    end
    wait_dig(6'h1F);
    checks++; if (led !== 7'h0E) begin errors++; $display("FAIL divzero_glyph_d5: got %h want 0e", led); end
  endtask

  task automatic test_protocol();
    bit ok;
    logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h04};
    txq.delete(); txt.delete();
    send4(8'h41, 8'h73, 8'h08, 8'h55);
    repeat (100) @(negedge clk);
    checks++; if (y !== 24'hFFFFFF) begin errors++; $display("FAIL proto_no_result_y: got %h want ffffff", y); end
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL proto_no_tx: got %0d pulses want 0", txq.size()); end
    send_byte(8'h73, 1'b0);
    send4(8'h73, 8'h08, 8'h73, 8'h02);
    wait_y(24'h000004, ok);
    checks++; if (!ok) begin errors++; $display("FAIL proto_y: got %h want 000004", y); end
    wait_tx(3);
    checks++; if (txq.size() != 3) begin errors++; $display("FAIL proto_tx_count: got %0d want 3", txq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL proto_tx_byte%0d: got %h want %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h02};
    send_byte(8'h73); send_byte(8'h09); send_byte(8'h73);
    @(negedge clk); rst = 1'b1; #20;
    checks++; if (y !== 24'h0) begin errors++; $display("FAIL midrst_y: got %h want 000000", y); end
    checks++; if (dig !== 6'h3F) begin errors++; $display("FAIL midrst_dig: got %b want 111111", dig); end
    rst = 1'b0;
    txq.delete(); txt.delete();
    send4(8'h73, 8'h06, 8'h73, 8'h03);
    wait_y(24'h000002, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_result_y: got %h want 000002", y); end
    wait_tx(3);
    repeat (2 * GAP) @(negedge clk);
    checks++; if (txq.size() != 3) begin errors++; $display("FAIL midrst_tx_count: got %0d want 3", txq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL midrst_tx_byte%0d: got %h want %h", i, txq[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nonexact();
    test_div_zero();
    test_protocol();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_div_display.md
Name: uart_div_display

Overview:
- Receives 8N1 UART bytes and runs a two-operand command protocol.
- Computes an integer quotient of the two operands.
- Shows the 24-bit quotient as 6 hex digits on a multiplexed 7-segment display.
- Presents the quotient as three bytes to an external UART transmitter.
- Sits between the board RX pin, the board's tx_uart and the LED digits.
- Internally it is a receiver, a command/divide controller and a display scanner.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (5208).
- SCAN_CLKS, 50_000, clocks each digit stays lit (1 ms).
- TX_GAP, 12*CLKS_PER_BIT, clocks between consecutive tx_ready pulses.
- CMD_BYTE, 8'h73, command prefix ('s').

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input, idle high.
- tx_data  out  8  byte for the external transmitter.
- tx_ready  out  1  one-cycle strobe: tx_data valid, start sending.
- y_to_led  out  24  latest quotient.
- led_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dig  out  6  digit selects, active-low one-hot; dig[0] is the least-significant nibble.

Behaviour:
- Reset, asynchronous: tx_data=0, tx_ready=0, y_to_led=0, led_out=7'h7F, dig=6'h3F.
- Reset clears all FSMs and counters; a reset mid-frame or mid-divide aborts the operation with no output.
- RX:
  - rx passes through a 2-FF synchronizer.
  - A falling edge while idle starts a frame; the start bit is re-checked low at CLKS_PER_BIT/2.
  - Each data bit is sampled at bit centre, LSB first.
  - If the stop bit samples 1, a one-cycle internal strobe fires with the byte; if it samples 0, the byte is discarded.
  - Receiver states: IDLE, START, DATA, STOP.
- Controller states: WAIT_CMD1, WAIT_A, WAIT_CMD2, WAIT_B, DIVIDE, SEND.
  - WAIT_CMD1: byte == CMD_BYTE goes to WAIT_A; any other byte is ignored.
  - WAIT_A: the byte, zero-extended to 24 bits, becomes the dividend; go to WAIT_CMD2.
  - WAIT_CMD2: byte == CMD_BYTE goes to WAIT_B; any other byte returns to WAIT_CMD1.
  - WAIT_B: the byte becomes the divisor; go to DIVIDE.
  - DIVIDE: restoring shift-subtract, one quotient bit per clock, 24 clocks.
    - On completion, y_to_led updates in the next cycle and holds until the next result.
    - Divisor 0 skips the divide and gives y_to_led = 24'hFFFFFF.
  - SEND:
    - Pulse tx_ready three times, TX_GAP clocks apart.
    - tx_data = y[23:16], then y[15:8], then y[7:0]; tx_data is stable while tx_ready is high and is held after.
    - Then return to WAIT_CMD1.
  - Bytes arriving during DIVIDE or SEND are ignored.
- Display:
  - A free-running counter advances the active digit every SCAN_CLKS.
  - Order: dig index 0..5, wrapping back to 0.
  - The first digit after reset is 0, enabled on the first clock after release.
  - led_out shows the hex glyph of y_to_led nibble [4k+3:4k] for active digit k.
  - Glyphs 0-F use standard shapes, with lowercase b and d.
  - dig and led_out change on the same clock edge.

Decomposition:
- Shared package holds:
  - the CLKS_PER_BIT derivation;
  - CMD_BYTE;
  - the receiver and controller state enums;
  - a 16-entry hex-to-segment constant table.
- Sub-module: uart_div_rx (receiver, byte strobe).
- The controller/divider and the scan logic stay in the top.

Test Plan:
- Reset: assert rst for 20 ns, then release. Outputs hold their reset values; dig cycles 111110, 111101, … every SCAN_CLKS.
- Basic: send 73,03,73,01 at 104160 ns/bit.
  - y_to_led = 24'h000003 about 26 clocks after the last stop bit.
  - tx_ready pulses 3× with tx_data 00, 00, 03.
  - Digit 0 shows '3' (led_out = 7'h30); other digits show '0' (7'h40).
- Non-exact divide: send 73,FF,73,10 → y_to_led = 24'h00000F; the digit 0 glyph is 'F' (7'h0E).
- Divide by zero: send 73,05,73,00 → y_to_led = 24'hFFFFFF; tx bytes FF, FF, FF.
- Protocol errors:
  - Send 41,73,08,55 → no result.
  - Then send 73,08,73,02 → y_to_led = 4.
  - A frame with stop bit 0 is ignored.
- Reset mid-operation: assert rst during WAIT_B, then send 73,06,73,03 → y_to_led = 2 and exactly three tx_ready pulses.
